// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: streams one feature map from memory to the convolutor
// in row-major order. It issues one read per cycle when there is room and
// carries column-edge flags alongside each pixel. A one-entry hold register
// absorbs the read beat that lands while the output is stalled.
module conv_stream_feeder #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int ADDR_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [7:0]          width,
  input  logic [7:0]          height,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic signed [7:0]   mem_rdata,
  output logic signed [7:0]   pixel_out,
  output logic                pixel_valid,
  input  logic                pixel_ready,
  output logic                paddingl,
  output logic                paddingr,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

  state_t state, state_nxt;

  logic [7:0]        w_q, h_q, row_q, col_q;
  logic [ADDR_W-1:0] addr_q;

  logic              rd_vld_p1, rd_l_p1, rd_r_p1;
  logic              out_vld_p2, out_l_p2, out_r_p2;
  logic signed [7:0] out_pix_p2;
  logic              hold_vld_p2, hold_l_p2, hold_r_p2;
  logic signed [7:0] hold_pix_p2;

  logic [7:0]        cur_w, cur_h, cur_row, cur_col;
  logic [ADDR_W-1:0] cur_addr;
  logic              xfer, issue, last_rd, empty_frame;
  logic [1:0]        occ_after;

  function automatic logic [7:0] clamp_dim(input logic [7:0] d, input int lim);
    if (32'(d) > lim) return lim[7:0];
    return d;
  endfunction

  // Read position: taken straight from the inputs in IDLE so the first read
  // can go out in the start cycle, otherwise from the running counters.
  always_comb begin
    cur_w    = w_q;
    cur_h    = h_q;
    cur_row  = row_q;
    cur_col  = col_q;
    cur_addr = addr_q;
    if (state == IDLE) begin
      cur_w    = clamp_dim(width, IMAGE_WIDTH);
      cur_h    = clamp_dim(height, IMAGE_HEIGHT);
      cur_row  = 8'd0;
      cur_col  = 8'd0;
      cur_addr = base_addr;
    end
  end

  assign xfer        = out_vld_p2 & pixel_ready;
  // Pixels still owned after this cycle: output + hold + beat in flight.
  assign occ_after   = 2'(out_vld_p2) + 2'(hold_vld_p2) + 2'(rd_vld_p1) - 2'(xfer);
  assign empty_frame = (cur_w == 8'd0) || (cur_h == 8'd0);
  assign last_rd     = (cur_row == cur_h - 8'd1) && (cur_col == cur_w - 8'd1);

  // Next-state, read strobe and status outputs.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        issue = start && !empty_frame;
        // An empty frame passes through DRAIN with nothing outstanding.
        if (start) state_nxt = (empty_frame || last_rd) ? DRAIN : STREAM;
      end
      STREAM: begin
        busy  = 1'b1;
        issue = (occ_after < 2'd2);
        if (issue && last_rd) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (occ_after == 2'd0) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) issue = 1'b0;
  end

  assign mem_rd_en   = issue;
  assign mem_addr    = issue ? cur_addr : '0;
  assign pixel_out   = out_pix_p2;
  assign pixel_valid = out_vld_p2;
  assign paddingl    = out_vld_p2 & out_l_p2;
  assign paddingr    = out_vld_p2 & out_r_p2;

  // State register, frame geometry and row/column/address counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      w_q    <= 8'd0;
      h_q    <= 8'd0;
      row_q  <= 8'd0;
      col_q  <= 8'd0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        w_q   <= cur_w;
        h_q   <= cur_h;
        row_q <= 8'd0;
        col_q <= 8'd0;
      end
      if (issue) begin
        addr_q <= cur_addr + ADDR_W'(1);
        if (cur_col == cur_w - 8'd1) begin
          col_q <= 8'd0;
          row_q <= cur_row + 8'd1;
        end else begin
          col_q <= cur_col + 8'd1;
          row_q <= cur_row;
        end
      end
    end
  end

  // ---- stage p1: read in flight; p2: output register + hold register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_p1   <= 1'b0;
      rd_l_p1     <= 1'b0;
      rd_r_p1     <= 1'b0;
      out_vld_p2  <= 1'b0;
      out_pix_p2  <= '0;
      out_l_p2    <= 1'b0;
      out_r_p2    <= 1'b0;
      hold_vld_p2 <= 1'b0;
      hold_pix_p2 <= '0;
      hold_l_p2   <= 1'b0;
      hold_r_p2   <= 1'b0;
    end else begin
      rd_vld_p1 <= issue;
      rd_l_p1   <= issue && (cur_col == 8'd0);
      rd_r_p1   <= issue && (cur_col == cur_w - 8'd1);
      if (out_vld_p2 && !pixel_ready) begin
        // Output stalled: it stays put; a landing beat parks in hold.
        if (!hold_vld_p2 && rd_vld_p1) begin
          hold_vld_p2 <= 1'b1;
          hold_pix_p2 <= mem_rdata;
          hold_l_p2   <= rd_l_p1;
          hold_r_p2   <= rd_r_p1;
        end
      end else if (hold_vld_p2) begin
        // Hold is older than any landing beat, so it goes out first.
        out_vld_p2  <= 1'b1;
        out_pix_p2  <= hold_pix_p2;
        out_l_p2    <= hold_l_p2;
        out_r_p2    <= hold_r_p2;
        hold_vld_p2 <= rd_vld_p1;
        hold_pix_p2 <= mem_rdata;
        hold_l_p2   <= rd_l_p1;
        hold_r_p2   <= rd_r_p1;
      end else begin
        out_vld_p2 <= rd_vld_p1;
        if (rd_vld_p1) begin
          out_pix_p2 <= mem_rdata;
          out_l_p2   <= rd_l_p1;
          out_r_p2   <= rd_r_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Bench for conv_stream_feeder: memory model plus a frame-level reference
// that lists expected addresses and pixels from row/column arithmetic.
module tb_conv_stream_feeder;

  localparam int AW = 16;
  localparam int IW = 16;
  localparam int IH = 16;

  logic              clk = 1'b0;
  logic              rst_n, start, mem_rd_en, pixel_valid, pixel_ready;
  logic              paddingl, paddingr, busy, done;
  logic [AW-1:0]     base_addr, mem_addr;
  logic [7:0]        width, height;
  logic signed [7:0] mem_rdata, pixel_out;

  logic signed [7:0] mem [0:65535];
  logic [AW-1:0]     aq[$];
  logic [9:0]        pq[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, mode = 0, st_cyc = 0;
  int first_vld, done_cyc, done_n, busy_n, xfer_n;
  logic chk_rst = 1'b0;
  logic prev_stall = 1'b0;
  logic [9:0] prev_out;

  conv_stream_feeder #(.IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .width(width), .height(height), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .paddingl(paddingl), .paddingr(paddingr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= 8'($urandom);
  end

  task automatic step();
    logic [AW-1:0] ea;
    logic [9:0]    ep;
    @(negedge clk);
    if (chk_rst) begin
      n_chk++;
      assert ({mem_rd_en, mem_addr, pixel_valid, pixel_out, paddingl, paddingr, busy, done} === '0)
        else begin n_fail++; $error("FAIL reset_outputs got %h want 0",
          {mem_rd_en, mem_addr, pixel_valid, pixel_out, paddingl, paddingr, busy, done}); end
    end
    if (mem_rd_en) begin
      n_chk++;
      assert (aq.size() != 0) else begin n_fail++; $error("FAIL extra_read addr=%h want none", mem_addr); end
      if (aq.size() != 0) begin
        ea = aq.pop_front();
        n_chk++;
        assert (mem_addr === ea) else begin n_fail++; $error("FAIL rd_addr got %h want %h", mem_addr, ea); end
      end
    end
    if (prev_stall) begin
      n_chk++;
      assert ({pixel_valid, pixel_out, paddingl, paddingr} === {1'b1, prev_out})
        else begin n_fail++; $error("FAIL stall_hold got %h want %h",
          {pixel_valid, pixel_out, paddingl, paddingr}, {1'b1, prev_out}); end
    end
    if (pixel_valid && first_vld < 0) first_vld = cyc;
    if (pixel_valid && pixel_ready) begin
      xfer_n++;
      n_chk++;
      assert (pq.size() != 0) else begin n_fail++; $error("FAIL extra_pixel got %h want none", pixel_out); end
      if (pq.size() != 0) begin
        ep = pq.pop_front();
        n_chk++;
        assert ({pixel_out, paddingl, paddingr} === ep)
          else begin n_fail++; $error("FAIL pixel got %h want %h", {pixel_out, paddingl, paddingr}, ep); end
      end
    end
    prev_stall = pixel_valid && !pixel_ready;
    prev_out   = {pixel_out, paddingl, paddingr};
    if (busy) busy_n++;
    if (done) begin
      done_n++;
      if (done_cyc < 0) done_cyc = cyc;
      n_chk++;
      assert (busy === 1'b0) else begin n_fail++; $error("FAIL busy_at_done got %b want 0", busy); end
    end
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       pixel_ready = 1'b1;
      1:       pixel_ready = (((cyc - st_cyc) % 4) == 0) || (((cyc - st_cyc) % 4) == 3);
      default: pixel_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic clear_stats();
    first_vld = -1; done_cyc = -1; done_n = 0; busy_n = 0; xfer_n = 0;
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input logic [7:0] w, input logic [7:0] h,
                           input int md, input bit restart);
    int we, he, n;
    we = (int'(w) > IW) ? IW : int'(w);
    he = (int'(h) > IH) ? IH : int'(h);
    n  = we * he;
    for (int r = 0; r < he; r++)
      for (int c = 0; c < we; c++) begin
        aq.push_back(AW'(int'(base) + r * we + c));
        pq.push_back({mem[AW'(int'(base) + r * we + c)], c == 0, c == we - 1});
      end
    mode = md;
    clear_stats();
    base_addr = base; width = w; height = h; start = 1'b1;
    st_cyc = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < n * 6 + 20 && done_cyc < 0; k++) begin
      if (restart && k == 4) begin
        base_addr = 16'h3000; width = 8'd2; height = 8'd2; start = 1'b1;
      end
      step();
      start = 1'b0;
    end
    for (int k = 0; k < 3; k++) step();
    n_chk++;
    assert (done_n == 1) else begin n_fail++; $error("FAIL done_count %0dx%0d got %0d want 1", we, he, done_n); end
    n_chk++;
    assert (pq.size() == 0 && aq.size() == 0)
      else begin n_fail++; $error("FAIL leftover pixels=%0d reads=%0d want 0", pq.size(), aq.size()); end
    if (md == 0) begin
      n_chk++;
      assert (done_cyc - st_cyc == n + 2)
        else begin n_fail++; $error("FAIL done_latency got %0d want %0d", done_cyc - st_cyc, n + 2); end
      if (n > 0) begin
        n_chk++;
        assert (first_vld - st_cyc == 2)
          else begin n_fail++; $error("FAIL first_valid got %0d want 2", first_vld - st_cyc); end
      end else begin
        n_chk++;
        assert (busy_n == 1) else begin n_fail++; $error("FAIL busy_cycles got %0d want 1", busy_n); end
      end
    end
    aq.delete(); pq.delete();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst_n = 1'b0; start = 1'b0; pixel_ready = 1'b1;
    base_addr = '0; width = '0; height = '0;
    clear_stats();
    step();
    chk_rst = 1'b1;
    step(); step();
    chk_rst = 1'b0;
    rst_n = 1'b1;
    step();

    run_frame(16'h0100, 8'd3, 8'd2, 0, 1'b0);
    run_frame(16'h0400, 8'd4, 8'd2, 1, 1'b0);
    run_frame(16'h0800, 8'd1, 8'd3, 0, 1'b0);
    run_frame(16'h0900, 8'd0, 8'd5, 0, 1'b0);
    run_frame(16'h0A00, 8'd4, 8'd4, 0, 1'b1);

    // Reset in the middle of a 4x4 frame, then a fresh 2x2 frame.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        aq.push_back(AW'(16'h0200 + r * 4 + c));
        pq.push_back({mem[AW'(16'h0200 + r * 4 + c)], c == 0, c == 3});
      end
    mode = 0; clear_stats();
    base_addr = 16'h0200; width = 8'd4; height = 8'd4; start = 1'b1;
    st_cyc = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 100 && xfer_n < 5; k++) step();
    n_chk++;
    assert (xfer_n == 5) else begin n_fail++; $error("FAIL pre_reset_pixels got %0d want 5", xfer_n); end
    rst_n = 1'b0;
    step();
    chk_rst = 1'b1;
    step(); step();
    chk_rst = 1'b0;
    rst_n = 1'b1;
    aq.delete(); pq.delete();
    for (int k = 0; k < 4; k++) step();
    n_chk++;
    assert (done_n == 0) else begin n_fail++; $error("FAIL done_after_reset got %0d want 0", done_n); end
    run_frame(16'h0500, 8'd2, 8'd2, 0, 1'b0);

    for (int f = 0; f < 4; f++)
      run_frame(AW'($urandom), 8'($urandom_range(1, 20)), 8'($urandom_range(1, 6)), 2, 1'b0);
    run_frame(16'hFFFD, 8'd3, 8'd3, 2, 1'b0);
    run_frame(16'h1000, 8'd2, 8'd20, 0, 1'b0);
    run_frame(16'h2000, 8'd40, 8'd1, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
